subbytes_multilane: RTL

SUBBYTES_MULTILANE -- requirements
Module: subbytes_multilane

---
 rtl/subbytes_multilane.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/subbytes_multilane.sv
// subbytes_multilane: AES SubBytes / InvSubBytes over a 128-bit block.
// LANES bytes are substituted per cycle, lowest bytes first. A start/done
// handshake frames each block, and the result is held until it is acknowledged.

package subbytes_gf_pkg;
    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // multiplicative inverse as a^254 (square-and-multiply); 0 maps to 0
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction
endpackage

// Forward S-box: inverse in GF(2^8) followed by the affine transform
module sbox_fwd (
    input  logic [7:0] a,
    output logic [7:0] y
);
    import subbytes_gf_pkg::*;
    logic [7:0] t;

    // affine: t ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63
    always_comb begin
        t = gf_inv(a);
        y = t ^ {t[6:0], t[7]} ^ {t[5:0], t[7:6]} ^ {t[4:0], t[7:5]} ^ {t[3:0], t[7:4]} ^ 8'h63;
    end
endmodule

// Inverse S-box: inverse affine transform followed by inversion in GF(2^8)
module sbox_inv (
    input  logic [7:0] a,
    output logic [7:0] y
);
    import subbytes_gf_pkg::*;
    logic [7:0] t;

    // inverse affine: rotl1 ^ rotl3 ^ rotl6 ^ 0x05
    always_comb begin
        t = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
        y = gf_inv(t);
    end
endmodule

module subbytes_multilane #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         inv,
    input  logic [127:0] state_in,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic         done,
    output logic         busy
);
    localparam int BEATS = 16 / LANES;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("subbytes_multilane: LANES must be 1, 2, 4, 8 or 16");
    end

    logic [1:0]             fsm;
    logic [CW-1:0]          cnt;
    logic [15:0][7:0]       blk;
    logic                   mode;
    logic [15:0][7:0]       res;
    logic [4:0]             base;
    logic [LANES-1:0][3:0]  sel;
    logic [LANES-1:0][7:0]  lane_in;
    logic [LANES-1:0][7:0]  lane_fwd;
    logic [LANES-1:0][7:0]  lane_inv;
    logic [LANES-1:0][7:0]  lane_out;

    assign state_out = res;
    assign busy      = (fsm == RUN);

    // byte index handled by each lane this beat: cnt*LANES + k
    always_comb begin
        base = 5'(cnt) * 5'(LANES);
        for (int k = 0; k < LANES; k++) begin
            sel[k]     = 4'(base + 5'(k));
            lane_in[k] = blk[sel[k]];
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        sbox_fwd u_fwd (.a(lane_in[k]), .y(lane_fwd[k]));
        sbox_inv u_inv (.a(lane_in[k]), .y(lane_inv[k]));
        assign lane_out[k] = mode ? lane_inv[k] : lane_fwd[k];
    end

    // control FSM, capture registers and result write-back
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm  <= IDLE;
            cnt  <= '0;
            blk  <= '0;
            mode <= 1'b0;
            res  <= '0;
            done <= 1'b0;
        end else if (start && fsm != RUN) begin
            // a new request supersedes any held result, even alongside out_ready
            blk  <= state_in;
            mode <= inv;
            cnt  <= '0;
            res  <= '0;
            done <= 1'b0;
            fsm  <= RUN;
        end else begin
            case (fsm)
                RUN: begin
                    for (int k = 0; k < LANES; k++) res[sel[k]] <= lane_out[k];
                    if (cnt == CW'(BEATS - 1)) begin
                        done <= 1'b1;
                        fsm  <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        done <= 1'b0;
                        fsm  <= IDLE;
                    end
                end
                IDLE: ;
                default: fsm <= IDLE;
            endcase
        end
    end
endmodule
